abuf_load_ctrl: RTL and testbench

Sequencer that drives the accumulation/bias buffer loader for one layer. It accepts a load command, walks the enabled transfer phases in fixed order, and for each phase configures and starts the loader. It issues one DDR read burst per phase and counts the returned beats. After all phases finish it signals done. It sits between the layer scheduler and the DDR-to-accum/bias-buffer datapath.

---
 rtl/abuf_load_ctrl_pkg.sv | 42 ++++
 rtl/abuf_load_ctrl.sv | 159 +++++++++++++++
 tb/tb_abuf_load_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/abuf_load_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : abuf_load_ctrl_pkg
// Description : Shared types for the accumulation/bias buffer load sequencer.
//               Loader transfer types, sequencer state encoding and the
//               lowest-set-bit helper used to walk the phase enables.
// Revision    : 1.0 - initial release
// ============================================================================
package abuf_load_ctrl_pkg;

    // Loader conf_trans_type values; bit i of the command phase enables
    // selects trans_type i.
    typedef enum logic [1:0] {
        TT_ABUF_DATA = 2'd0,
        TT_ABUF_TAIL = 2'd1,
        TT_BBUF_DATA = 2'd2,
        TT_BBUF_TAIL = 2'd3
    } trans_type_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_START = 3'd2,
        ST_REQ   = 3'd3,
        ST_RECV  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    // Index of the lowest set bit; only meaningful when bits != 0.
    function automatic logic [1:0] lowest_set(input logic [3:0] bits);
        logic [1:0] idx;
        idx = 2'd0;
        if (bits[0])      idx = 2'd0;
        else if (bits[1]) idx = 2'd1;
        else if (bits[2]) idx = 2'd2;
        else if (bits[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/abuf_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : abuf_load_ctrl
// Description : Per-layer sequencer for the accum/bias buffer loader. Latches
//               a load command, walks the enabled phases (lowest bit first),
//               and for each phase starts the loader, issues one DDR read
//               burst, counts returned beats and waits for the loader's
//               write pipeline to drain. Pulses done when all phases finish.
// Ports       : clk/rst            - clock, synchronous active-high reset
//               cmd_*              - load command handshake and fields
//               rd_req_*           - DDR read burst request
//               ddr_valid/ready    - DDR beat handshake (shared with loader)
//               ld_*               - loader configuration and start pulse
//               busy/done          - status
// Revision    : 1.0 - initial release
// ============================================================================
module abuf_load_ctrl
    import abuf_load_ctrl_pkg::*;
#(
    parameter int PE_NUM     = 32,
    parameter int DDR_AW     = 32,
    parameter int DDR_W      = 512,
    parameter int BEAT_BYTES = DDR_W / 8,
    parameter int DRAIN_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_phase_en,
    input  logic [DDR_AW-1:0] cmd_ddr_addr,
    input  logic [7:0]        cmd_num,
    input  logic [PE_NUM-1:0] cmd_mask,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [DDR_AW-1:0] rd_req_addr,
    output logic [7:0]        rd_req_len,
    input  logic              ddr_valid,
    output logic              ddr_ready,
    output logic              ld_start,
    output logic [1:0]        ld_trans_type,
    output logic [7:0]        ld_trans_num,
    output logic [PE_NUM-1:0] ld_mask,
    output logic              busy,
    output logic              done
);

    localparam int                DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DDR_AW-1:0] STRIDE  = DDR_AW'(BEAT_BYTES);

    state_e               state;
    state_e               state_nxt;
    logic [3:0]           phase_rem;
    logic [DDR_AW-1:0]    addr;
    logic [7:0]           num;
    logic [PE_NUM-1:0]    mask;
    logic [7:0]           beat_cnt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [1:0]           pick;
    logic                 sel_go;
    logic                 beat;
    logic                 last_beat;
    logic                 drain_last;

    assign pick       = lowest_set(phase_rem);
    assign sel_go     = (phase_rem != 4'd0) && (num != 8'd0);
    assign beat       = (state == ST_RECV) && ddr_valid;
    // Counter only ever reaches num-1 inside RECV, so the burst can never
    // be over-counted: the beat that hits num leaves RECV.
    assign last_beat  = beat && ((beat_cnt + 8'd1) == num);
    assign drain_last = (drain_cnt == DRAIN_W'(DRAIN_CYC - 1));

    assign rd_req_addr = addr;
    assign rd_req_len  = num;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        cmd_ready    = 1'b0;
        rd_req_valid = 1'b0;
        ddr_ready    = 1'b0;
        ld_start     = 1'b0;
        done         = 1'b0;
        busy         = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid) state_nxt = ST_SEL;
            end
            ST_SEL: begin
                state_nxt = sel_go ? ST_START : ST_DONE;
            end
            ST_START: begin
                ld_start  = 1'b1;
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                rd_req_valid = 1'b1;
                if (rd_req_ready) state_nxt = ST_RECV;
            end
            ST_RECV: begin
                ddr_ready = 1'b1;
                if (last_beat) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_last) state_nxt = ST_SEL;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_rem     <= 4'd0;
            addr          <= '0;
            num           <= 8'd0;
            mask          <= '0;
            beat_cnt      <= 8'd0;
            drain_cnt     <= '0;
            ld_trans_type <= 2'd0;
            ld_trans_num  <= 8'd0;
            ld_mask       <= '0;
        end else begin
            if (state == ST_IDLE && cmd_valid) begin
                phase_rem <= cmd_phase_en;
                addr      <= cmd_ddr_addr;
                num       <= cmd_num;
                mask      <= cmd_mask;
            end
            // Loader config is captured only when a phase is committed, so
            // it holds from START through DRAIN and keeps its value in IDLE.
            if (state == ST_SEL && sel_go) begin
                phase_rem     <= phase_rem & ~(4'b0001 << pick);
                ld_trans_type <= pick;
                ld_trans_num  <= num;
                ld_mask       <= mask;
            end
            if (beat) begin
                beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
            end
            if (last_beat) begin
                addr <= addr + DDR_AW'(num) * STRIDE;
            end
            if (state == ST_DRAIN) begin
                drain_cnt <= drain_last ? '0 : drain_cnt + DRAIN_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_abuf_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_abuf_load_ctrl
// Description : Self-checking bench for abuf_load_ctrl. Each command's phase
//               list (type, burst address) is derived from the enables and
//               num, then the DUT is driven with random ready/valid traffic
//               and every observable event is checked against that list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_abuf_load_ctrl;

    localparam int PE_NUM     = 32;
    localparam int DDR_AW     = 32;
    localparam int BEAT_BYTES = 64;
    localparam int DRAIN_CYC  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_phase_en;
    logic [DDR_AW-1:0] cmd_ddr_addr;
    logic [7:0]        cmd_num;
    logic [PE_NUM-1:0] cmd_mask;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [DDR_AW-1:0] rd_req_addr;
    logic [7:0]        rd_req_len;
    logic              ddr_valid;
    logic              ddr_ready;
    logic              ld_start;
    logic [1:0]        ld_trans_type;
    logic [7:0]        ld_trans_num;
    logic [PE_NUM-1:0] ld_mask;
    logic              busy;
    logic              done;

    int n_assert = 0;
    int n_fail   = 0;

    abuf_load_ctrl #(
        .PE_NUM     (PE_NUM),
        .DDR_AW     (DDR_AW),
        .DDR_W      (BEAT_BYTES * 8),
        .BEAT_BYTES (BEAT_BYTES),
        .DRAIN_CYC  (DRAIN_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_phase_en  (cmd_phase_en),
        .cmd_ddr_addr  (cmd_ddr_addr),
        .cmd_num       (cmd_num),
        .cmd_mask      (cmd_mask),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_req_len    (rd_req_len),
        .ddr_valid     (ddr_valid),
        .ddr_ready     (ddr_ready),
        .ld_start      (ld_start),
        .ld_trans_type (ld_trans_type),
        .ld_trans_num  (ld_trans_num),
        .ld_mask       (ld_mask),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input logic in_rst);
        check("rst_cmd_ready",     64'(cmd_ready),     64'(!in_rst));
        check("rst_rd_req_valid",  64'(rd_req_valid),  64'd0);
        check("rst_rd_req_addr",   64'(rd_req_addr),   64'd0);
        check("rst_rd_req_len",    64'(rd_req_len),    64'd0);
        check("rst_ddr_ready",     64'(ddr_ready),     64'd0);
        check("rst_ld_start",      64'(ld_start),      64'd0);
        check("rst_ld_trans_type", 64'(ld_trans_type), 64'd0);
        check("rst_ld_trans_num",  64'(ld_trans_num),  64'd0);
        check("rst_ld_mask",       64'(ld_mask),       64'd0);
        check("rst_busy",          64'(busy),          64'd0);
        check("rst_done",          64'(done),          64'd0);
    endtask

    // Issue one command and follow it to done. rdy_pct / val_pct set the
    // probability of rd_req_ready / ddr_valid; hold_req forces the first
    // hold_req request cycles of each phase to see ready low.
    task automatic run_cmd(input logic [3:0] en, input logic [31:0] a, input logic [7:0] n,
                           input logic [31:0] m, input int rdy_pct, input int val_pct,
                           input int hold_req);
        int          exp_type[$];
        logic [31:0] exp_addr[$];
        logic [31:0] k;
        int          ph, beats, start_cyc, last_beat_cyc, req_wait, cyc;
        bit          req_done, finished;

        // Reference: enabled phases in ascending order, consecutive bursts
        // laid out back to back in DDR; num == 0 means no phases at all.
        for (int i = 0; i < 4; i++) begin
            if (en[i] && n != 8'd0) begin
                k = 32'(exp_type.size());
                exp_type.push_back(i);
                exp_addr.push_back(a + k * 32'(n) * 32'(BEAT_BYTES));
            end
        end

        @(negedge clk);
        check("cmd_ready_before", 64'(cmd_ready), 64'd1);
        cmd_valid    = 1'b1;
        cmd_phase_en = en;
        cmd_ddr_addr = a;
        cmd_num      = n;
        cmd_mask     = m;
        ddr_valid    = 1'b1;   // must be ignored while idle
        rd_req_ready = 1'($urandom_range(1));

        ph = 0; beats = 0; start_cyc = 0; last_beat_cyc = -100; req_wait = 0;
        req_done = 1'b0; finished = 1'b0;
        for (cyc = 1; cyc <= 3000 && !finished; cyc++) begin
            @(negedge clk);
            cmd_valid    = 1'b0;
            cmd_phase_en = 4'($urandom);
            cmd_ddr_addr = $urandom;
            cmd_num      = 8'($urandom);
            cmd_mask     = $urandom;
            check("busy", 64'(busy), 64'd1);
            if (ld_start) begin
                check("start_in_range", 64'(ph < exp_type.size()), 64'd1);
                if (ph < exp_type.size()) begin
                    check("ld_trans_type", 64'(ld_trans_type), 64'(exp_type[ph]));
                    check("ld_trans_num",  64'(ld_trans_num),  64'(n));
                    check("ld_mask",       64'(ld_mask),       64'(m));
                end
                if (ph == 0) check("start_latency", 64'(cyc), 64'd2);
                else begin
                    check("beats_prev_phase", 64'(beats), 64'(n));
                    check("start_after_drain", 64'(cyc), 64'(last_beat_cyc + DRAIN_CYC + 2));
                end
                ph++; beats = 0; req_done = 1'b0; req_wait = 0; start_cyc = cyc;
            end
            if (ph > 0 && ph <= exp_type.size() && !done) begin
                check("ld_type_stable", 64'(ld_trans_type), 64'(exp_type[ph-1]));
            end
            if (rd_req_valid) begin
                check("req_has_phase", 64'(ph > 0), 64'd1);
                check("req_no_ddr_ready", 64'(ddr_ready), 64'd0);
                if (req_wait == 0) check("req_latency", 64'(cyc), 64'(start_cyc + 1));
                if (ph > 0 && ph <= exp_type.size()) begin
                    check("req_addr", 64'(rd_req_addr), 64'(exp_addr[ph-1]));
                    check("req_len",  64'(rd_req_len),  64'(n));
                end
                rd_req_ready = (req_wait >= hold_req) &&
                               (($urandom_range(99) < 32'(rdy_pct)) || req_wait > hold_req + 40);
                req_wait++;
                if (rd_req_ready) req_done = 1'b1;
            end else begin
                rd_req_ready = 1'($urandom_range(1));
            end
            ddr_valid = ($urandom_range(99) < 32'(val_pct));
            if (ddr_ready) begin
                check("ready_after_req", 64'(req_done), 64'd1);
                check("ready_below_num", 64'(beats < int'(n)), 64'd1);
                if (ddr_valid) begin
                    beats++;
                    if (beats == int'(n)) last_beat_cyc = cyc;
                end
            end
            if (done) begin
                check("done_phase_count", 64'(ph), 64'(exp_type.size()));
                if (exp_type.size() == 0) check("done_latency", 64'(cyc), 64'd2);
                else begin
                    check("beats_last_phase", 64'(beats), 64'(n));
                    check("done_after_drain", 64'(cyc), 64'(last_beat_cyc + DRAIN_CYC + 2));
                end
                finished = 1'b1;
            end
        end
        if (!finished) check("cmd_timeout", 64'd0, 64'd1);

        @(negedge clk);
        check("cmd_ready_after", 64'(cmd_ready), 64'd1);
        check("busy_after",      64'(busy),      64'd0);
        check("done_single",     64'(done),      64'd0);
        ddr_valid    = 1'b0;
        rd_req_ready = 1'b0;
    endtask

    initial begin : stim
        int beats;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_phase_en = 4'd0;
        cmd_ddr_addr = '0;
        cmd_num      = 8'd0;
        cmd_mask     = '0;
        rd_req_ready = 1'b0;
        ddr_valid    = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs(1'b1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs(1'b0);

        // Single phase, full mask
        run_cmd(4'b0001, 32'h0000_1000, 8'd16, 32'hFFFF_FFFF, 100, 100, 0);
        // Two phases: type 1 at 0x0, type 3 at 0x100
        run_cmd(4'b1010, 32'h0000_0000, 8'd4, 32'h1234_5678, 100, 100, 0);
        // Request held off for 10 cycles per phase
        run_cmd(4'b0011, 32'h0000_3000, 8'd5, 32'h0F0F_0F0F, 100, 100, 10);
        // Empty commands
        run_cmd(4'b0000, 32'h0000_4000, 8'd8, 32'hAAAA_AAAA, 100, 100, 0);
        run_cmd(4'b1111, 32'h0000_5000, 8'd0, 32'h5555_5555, 100, 100, 0);
        // Sparse beats and stray valids
        run_cmd(4'b0101, 32'h0000_0400, 8'd7, 32'hDEAD_BEEF, 60, 40, 0);
        // Address wrap across the top of DDR space
        run_cmd(4'b1111, 32'hFFFF_FF80, 8'd3, 32'hCAFE_F00D, 80, 70, 0);
        // Single-beat phases
        run_cmd(4'b1100, 32'h0001_0000, 8'd1, 32'h0000_0001, 100, 100, 0);

        // Reset in the middle of a burst
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_phase_en = 4'b0001;
        cmd_ddr_addr = 32'h0000_2000;
        cmd_num      = 8'd16;
        cmd_mask     = $urandom;
        rd_req_ready = 1'b1;
        beats        = 0;
        for (int c = 0; c < 100 && beats < 5; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            ddr_valid = 1'b1;
            if (ddr_ready) beats++;
        end
        check("reset_setup_beats", 64'(beats), 64'd5);
        @(negedge clk);
        check("pre_reset_recv", 64'(ddr_ready), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs(1'b1);
        rst       = 1'b0;
        ddr_valid = 1'b0;
        run_cmd(4'b0001, 32'h0000_2000, 8'd16, 32'h8765_4321, 100, 100, 0);

        // Randomized commands
        for (int r = 0; r < 12; r++) begin
            run_cmd(4'($urandom), {$urandom_range(32'hFFFF), 6'd0} << 4, 8'($urandom_range(20)),
                    $urandom, int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                    int'($urandom_range(3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
